// File: rtl/ds_operand_fwd.sv
// ds_operand_fwd: decode-stage pipeline register with register-file read,
// priority operand forwarding from NFWD producer stages, RAW interlock,
// flush, and a saturating dependency-stall counter.
module ds_operand_fwd #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NFWD      = 3,
  parameter int unsigned PAYLOAD_W = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_allowin,
  input  logic [PAYLOAD_W-1:0]     in_payload,
  input  logic [4:0]               in_rj,
  input  logic [4:0]               in_rkd,
  input  logic                     in_use_rj,
  input  logic                     in_use_rkd,
  input  logic                     flush,
  output logic [4:0]               rf_raddr1,
  output logic [4:0]               rf_raddr2,
  input  logic [DATA_W-1:0]        rf_rdata1,
  input  logic [DATA_W-1:0]        rf_rdata2,
  input  logic [NFWD-1:0]          fwd_valid,
  input  logic [5*NFWD-1:0]        fwd_dest,
  input  logic [NFWD-1:0]          fwd_ready,
  input  logic [DATA_W*NFWD-1:0]   fwd_data,
  output logic                     out_valid,
  input  logic                     out_allowin,
  output logic [PAYLOAD_W-1:0]     out_payload,
  output logic [DATA_W-1:0]        out_rj_value,
  output logic [DATA_W-1:0]        out_rkd_value,
  output logic                     dep_stall,
  output logic [CNT_W-1:0]         stall_cnt
);

  logic                 valid_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [4:0]           rj_q;
  logic [4:0]           rkd_q;
  logic                 use_rj_q;
  logic                 use_rkd_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 rj_wait;
  logic                 rkd_wait;
  logic [DATA_W-1:0]    rj_val;
  logic [DATA_W-1:0]    rkd_val;
  logic                 ready_go;

  // Returns {wait, value}. Only the youngest matching producer is considered,
  // so an older ready result can never hide a younger one still in flight.
  function automatic logic [DATA_W:0] resolve(
    input logic                   use_s,
    input logic [4:0]             src,
    input logic [DATA_W-1:0]      rf_val,
    input logic [NFWD-1:0]        v,
    input logic [5*NFWD-1:0]      d,
    input logic [NFWD-1:0]        r,
    input logic [DATA_W*NFWD-1:0] data
  );
    logic              found;
    logic              stall;
    logic [DATA_W-1:0] val;
    found = 1'b0;
    stall = 1'b0;
    val   = rf_val;
    for (int unsigned i = 0; i < NFWD; i++) begin
      if (!found && use_s && (src != 5'd0) && v[i] && (d[5*i +: 5] == src)) begin
        found = 1'b1;
        if (r[i]) val = data[DATA_W*i +: DATA_W];
        else      stall = 1'b1;
      end
    end
    return {stall, val};
  endfunction

  // Per-source operand resolution, recomputed every cycle from the stage regs.
  always_comb begin
    {rj_wait, rj_val}   = resolve(use_rj_q, rj_q, rf_rdata1,
                                  fwd_valid, fwd_dest, fwd_ready, fwd_data);
    {rkd_wait, rkd_val} = resolve(use_rkd_q, rkd_q, rf_rdata2,
                                  fwd_valid, fwd_dest, fwd_ready, fwd_data);
  end

  // Handshake and status outputs.
  always_comb begin
    dep_stall     = valid_q && (rj_wait || rkd_wait);
    ready_go      = valid_q && !dep_stall;
    out_valid     = ready_go && !flush;
    in_allowin    = !valid_q || (ready_go && out_allowin) || flush;
    rf_raddr1     = rj_q;
    rf_raddr2     = rkd_q;
    out_payload   = payload_q;
    out_rj_value  = rj_val;
    out_rkd_value = rkd_val;
    stall_cnt     = cnt_q;
  end

  // Stage register and stall counter; flush beats a same-cycle incoming payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      rj_q      <= '0;
      rkd_q     <= '0;
      use_rj_q  <= 1'b0;
      use_rkd_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (flush)           valid_q <= 1'b0;
      else if (in_allowin) valid_q <= in_valid;

      if (in_valid && in_allowin && !flush) begin
        payload_q <= in_payload;
        rj_q      <= in_rj;
        rkd_q     <= in_rkd;
        use_rj_q  <= in_use_rj;
        use_rkd_q <= in_use_rkd;
      end

      if (dep_stall && !flush && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_ds_operand_fwd.sv
// Directed self-checking bench for ds_operand_fwd. A second instance with a
// 2-bit counter shares all inputs to exercise counter saturation.
module tb_ds_operand_fwd;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_allowin;
  logic [63:0]  in_payload;
  logic [4:0]   in_rj;
  logic [4:0]   in_rkd;
  logic         in_use_rj;
  logic         in_use_rkd;
  logic         flush;
  logic [4:0]   rf_raddr1;
  logic [4:0]   rf_raddr2;
  logic [31:0]  rf_rdata1;
  logic [31:0]  rf_rdata2;
  logic [2:0]   fwd_valid;
  logic [14:0]  fwd_dest;
  logic [2:0]   fwd_ready;
  logic [95:0]  fwd_data;
  logic         out_valid;
  logic         out_allowin;
  logic [63:0]  out_payload;
  logic [31:0]  out_rj_value;
  logic [31:0]  out_rkd_value;
  logic         dep_stall;
  logic [15:0]  stall_cnt;

  logic         sat_in_allowin;
  logic [4:0]   sat_raddr1;
  logic [4:0]   sat_raddr2;
  logic         sat_out_valid;
  logic [63:0]  sat_out_payload;
  logic [31:0]  sat_rj_value;
  logic [31:0]  sat_rkd_value;
  logic         sat_dep_stall;
  logic [1:0]   sat_stall_cnt;

  int checks = 0;
  int errors = 0;

  // Regfile model: r0 reads 0, rN reads 0xA000_00NN on port 1, 0xB000_00NN on port 2.
  assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'd0 : (32'hA000_0000 | {27'd0, rf_raddr1});
  assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'd0 : (32'hB000_0000 | {27'd0, rf_raddr2});

  ds_operand_fwd #(.DATA_W(32), .NFWD(3), .PAYLOAD_W(64), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_allowin(in_allowin), .in_payload(in_payload),
    .in_rj(in_rj), .in_rkd(in_rkd), .in_use_rj(in_use_rj), .in_use_rkd(in_use_rkd),
    .flush(flush),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_allowin(out_allowin), .out_payload(out_payload),
    .out_rj_value(out_rj_value), .out_rkd_value(out_rkd_value),
    .dep_stall(dep_stall), .stall_cnt(stall_cnt)
  );

  ds_operand_fwd #(.DATA_W(32), .NFWD(3), .PAYLOAD_W(64), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_allowin(sat_in_allowin), .in_payload(in_payload),
    .in_rj(in_rj), .in_rkd(in_rkd), .in_use_rj(in_use_rj), .in_use_rkd(in_use_rkd),
    .flush(flush),
    .rf_raddr1(sat_raddr1), .rf_raddr2(sat_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
    .out_valid(sat_out_valid), .out_allowin(out_allowin), .out_payload(sat_out_payload),
    .out_rj_value(sat_rj_value), .out_rkd_value(sat_rkd_value),
    .dep_stall(sat_dep_stall), .stall_cnt(sat_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [63:0] p, input logic [4:0] rj, input logic [4:0] rkd,
                       input logic urj, input logic urkd);
    in_valid   = 1'b1;
    in_payload = p;
    in_rj      = rj;
    in_rkd     = rkd;
    in_use_rj  = urj;
    in_use_rkd = urkd;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    in_payload = 64'd0;
    in_rj      = 5'd0;
    in_rkd     = 5'd0;
    in_use_rj  = 1'b0;
    in_use_rkd = 1'b0;
  endtask

  // Producer set: fwd_valid/ready as {WS,MS,ES}; dests and data given per stage.
  task automatic prod(input logic [2:0] v, input logic [2:0] r,
                      input logic [4:0] d_es, input logic [4:0] d_ms, input logic [4:0] d_ws,
                      input logic [31:0] x_es, input logic [31:0] x_ms, input logic [31:0] x_ws);
    fwd_valid = v;
    fwd_ready = r;
    fwd_dest  = {d_ws, d_ms, d_es};
    fwd_data  = {x_ws, x_ms, x_es};
  endtask

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    out_allowin = 1'b1;
    idle();
    prod(3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    tick();
    tick();
    #2;
    // Reset state
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_dep_stall", dep_stall, 1'b0);
    chk("rst_allowin",   in_allowin, 1'b1);
    chk("rst_raddr1",    rf_raddr1, 5'd0);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    reset = 1'b0;
    tick();

    // Back-to-back, no hazards
    for (int i = 0; i < 6; i++) begin
      if (i < 4) issue(64'hC0DE_0000_0000_1000 + 64'(i), 5'd5, 5'd6, 1'b1, 1'b1);
      else       idle();
      #2;
      if (i >= 1 && i <= 4) begin
        chk("b2b_valid",   out_valid, 1'b1);
        chk("b2b_payload", out_payload, 64'hC0DE_0000_0000_1000 + 64'(i - 1));
        chk("b2b_rj",      out_rj_value, 32'hA000_0005);
        chk("b2b_rkd",     out_rkd_value, 32'hB000_0006);
      end else if (i == 5) begin
        chk("b2b_drain", out_valid, 1'b0);
      end
      tick();
    end
    chk("b2b_cnt", stall_cnt, 16'd0);

    // Priority: ES and MS both write r7
    prod(3'b011, 3'b111, 5'd7, 5'd7, 5'd0, 32'h11, 32'h22, 32'h33);
    issue(64'h2222_0000_0000_0001, 5'd7, 5'd9, 1'b1, 1'b1);
    tick();
    idle();
    out_allowin = 1'b0;
    #2;
    chk("pri_es",    out_rj_value, 32'h11);
    chk("pri_rkd",   out_rkd_value, 32'hB000_0009);
    chk("pri_valid", out_valid, 1'b1);
    prod(3'b011, 3'b111, 5'd8, 5'd7, 5'd0, 32'h11, 32'h22, 32'h33);
    #1;
    chk("pri_ms", out_rj_value, 32'h22);
    // Younger unready hit must not be masked by older ready hit
    prod(3'b011, 3'b110, 5'd7, 5'd7, 5'd0, 32'h11, 32'h22, 32'h33);
    #1;
    chk("pri_mask_stall", dep_stall, 1'b1);
    chk("pri_mask_valid", out_valid, 1'b0);
    prod(3'b011, 3'b111, 5'd8, 5'd7, 5'd0, 32'h11, 32'h22, 32'h33);
    tick();
    #2;
    // Backpressure holds payload and does not count
    chk("bp_payload", out_payload, 64'h2222_0000_0000_0001);
    chk("bp_allowin", in_allowin, 1'b0);
    chk("bp_cnt",     stall_cnt, 16'd0);
    out_allowin = 1'b1;
    prod(3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    tick();

    // Load-use on ES, one cycle unready
    prod(3'b001, 3'b000, 5'd3, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    issue(64'h3333_0000_0000_0003, 5'd1, 5'd3, 1'b1, 1'b1);
    tick();
    idle();
    #2;
    chk("lu_stall",   dep_stall, 1'b1);
    chk("lu_allowin", in_allowin, 1'b0);
    chk("lu_valid0",  out_valid, 1'b0);
    tick();
    prod(3'b001, 3'b001, 5'd3, 5'd0, 5'd0, 32'h0000_DEAD, 32'd0, 32'd0);
    #2;
    chk("lu_valid1", out_valid, 1'b1);
    chk("lu_rkd",    out_rkd_value, 32'h0000_DEAD);
    chk("lu_rj",     out_rj_value, 32'hA000_0001);
    chk("lu_cnt",    stall_cnt, 16'd1);
    tick();

    // r0 source and ES writing r0 unready
    prod(3'b001, 3'b000, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
    issue(64'h4444_0000_0000_0004, 5'd0, 5'd4, 1'b1, 1'b1);
    tick();
    idle();
    #2;
    chk("r0_stall", dep_stall, 1'b0);
    chk("r0_valid", out_valid, 1'b1);
    chk("r0_value", out_rj_value, 32'd0);
    tick();
    // Unused rkd matching unready ES
    prod(3'b001, 3'b000, 5'd4, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
    issue(64'h5555_0000_0000_0005, 5'd2, 5'd4, 1'b1, 1'b0);
    tick();
    idle();
    #2;
    chk("unused_stall", dep_stall, 1'b0);
    chk("unused_rkd",   out_rkd_value, 32'hB000_0004);
    tick();

    // Flush during stall with simultaneous in_valid
    prod(3'b001, 3'b000, 5'd3, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    issue(64'h6666_0000_0000_0006, 5'd3, 5'd1, 1'b1, 1'b1);
    tick();
    issue(64'h7777_0000_0000_0007, 5'd9, 5'd9, 1'b1, 1'b1);
    flush = 1'b1;
    #2;
    chk("fl_allowin", in_allowin, 1'b1);
    chk("fl_outv",    out_valid, 1'b0);
    tick();
    flush = 1'b0;
    idle();
    #2;
    chk("fl_valid0",  out_valid, 1'b0);
    chk("fl_stall0",  dep_stall, 1'b0);
    chk("fl_dropped", rf_raddr1, 5'd3);
    chk("fl_payload", out_payload, 64'h6666_0000_0000_0006);
    chk("fl_cnt",     stall_cnt, 16'd1);

    // Saturation on the 2-bit counter, then reset mid-stall
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    chk("sat_rst_cnt", sat_stall_cnt, 2'd0);
    issue(64'h8888_0000_0000_0008, 5'd3, 5'd0, 1'b1, 1'b0);
    tick();
    idle();
    for (int k = 1; k <= 5; k++) begin
      tick();
      #2;
      chk("sat_cnt", sat_stall_cnt, (k < 3) ? 2'(k) : 2'd3);
      chk("wide_cnt", stall_cnt, 16'(k));
    end
    reset = 1'b1;
    flush = 1'b1;
    issue(64'h9999_0000_0000_0009, 5'd3, 5'd3, 1'b1, 1'b1);
    tick();
    reset = 1'b0;
    flush = 1'b0;
    idle();
    #2;
    chk("mid_rst_cnt",   stall_cnt, 16'd0);
    chk("mid_rst_sat",   sat_stall_cnt, 2'd0);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_stall", dep_stall, 1'b0);
    chk("mid_rst_raddr", rf_raddr1, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
